array_feeder: RTL
=================

Name: array_feeder

Overview:
- Row buffer and diagonal-skew feeder that sits directly upstream of the 4x4 weight-stationary systolic array.
- Accepts activation rows (one DATA_W value per lane) over a valid/ready handshake and stores up to DEPTH rows.
- On a start pulse, streams the stored rows into the array with lane k delayed k cycles, zero-padded.
- Drives the array's enable input so that enable lines up with lane 0 data.

Parameters:
- DATA_W, 8, width of one activation value.
- LANES, 4, number of array rows/lanes; lane k is skewed by k cycles.
- DEPTH, 4, maximum rows buffered per batch; power of 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  reset, asynchronous, active-high; clears all state and outputs.
- in_valid  input  1  write request for one row.
- in_ready  output  1  row accepted when in_valid && in_ready.
- in_data  input  LANES*DATA_W  row; lane k = in_data[k*DATA_W +: DATA_W].
- start  input  1  single-cycle pulse; begins streaming the buffered batch.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  single-cycle pulse on the last DRAIN cycle.
- row_count  output  $clog2(DEPTH)+1  rows currently buffered.
- en_out  output  1  array enable; high exactly while lane 0 carries valid data.
- a1_out..a4_out  output  DATA_W each  lane 0..3 activations to the array.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, buffer pointers and row_count = 0;
  - all skew registers, a*_out, en_out, busy, done = 0.
- Reset mid-stream aborts the batch with no done pulse; the buffer is emptied.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - in_ready = (row_count < DEPTH) && !start. This is combinational on start.
  - An accepted row is written at wr_ptr; wr_ptr and row_count increment.
  - in_valid while full is not accepted; in_data is ignored and nothing changes.
- IDLE -> STREAM when start=1 and row_count>0.
  - start with row_count=0 is ignored; no done pulse.
  - start while busy is ignored.
- STREAM (row_count cycles, N):
  - Each cycle, read row at rd_ptr.
  - Lane 0 value goes to the a1_out register; lane k value enters a k-deep shift register feeding a(k+1)_out.
  - en_out register = 1.
  - in_ready = 0.
  - After N reads -> DRAIN.
- DRAIN (LANES-1 cycles):
  - Zeros are pushed into all lane inputs; en_out = 0.
  - done = 1 on the final DRAIN cycle.
  - Then -> IDLE with row_count, rd_ptr and wr_ptr = 0.
- Latency, with start sampled at edge t:
  - en_out and row 0 lane 0 are visible in cycle t+1.
  - Row r lane k is visible in cycle t+1+r+k.
  - Last nonzero output is in cycle t+N+LANES-1, the same cycle as done.
- Output rules:
  - All outputs are registered except in_ready.
  - Lanes not carrying valid data output 0; the array must see zeros, not stale values.
- The buffer is never read and written in the same cycle, because writes happen only in IDLE.
- No arithmetic beyond pointer and count increments. Pointers are $clog2(DEPTH) wide and wrap naturally; the batch resets them to 0.

Decomposition:
- Shared package (array_pkg): DATA_W, LANES, DEPTH, the state enum typedef, and a lane-slice helper.
  - The consuming array uses the same DATA_W and LANES.
- One sub-module is natural: skew_delay, parameterised by DELAY and DATA_W.
  - A DELAY-deep register chain with async active-high reset to 0.
  - Instantiated per lane with DELAY = k via a generate loop; DELAY=0 is a passthrough register stage aligned with lane 0.

Test Plan:
- Reset idle: hold rst_b=1 for 2 cycles, then release -> all outputs 0, in_ready=1, row_count=0, busy=0.
- Full batch:
  - Stimulus: load rows (1,2,3,4), (5,6,7,8), (9,10,11,12), (13,14,15,16) (lane0..3), then start at t.
  - Required (a1..a4):
    - t+1: (1,0,0,0), en_out=1.
    - t+2: (5,2,0,0).
    - t+3: (9,6,3,0).
    - t+4: (13,10,7,4), en_out=1.
    - t+5: (0,14,11,8), en_out=0.
    - t+6: (0,0,15,12).
    - t+7: (0,0,0,16), done=1.
    - t+8: all 0, busy=0, row_count=0.
- Full and back-pressure:
  - Stimulus: write 4 rows, then hold in_valid with row (99,99,99,99).
  - Required: in_ready=0 and row_count stays 4; the subsequent stream never shows 99.
- Start edge cases:
  - start with row_count=0 -> no busy, no done.
  - start together with in_valid in IDLE (2 rows buffered) -> write refused, 2-row stream, done at t+5.
- Reset mid-stream:
  - Stimulus: assert rst_b at t+3 of a 4-row batch.
  - Required: outputs 0 immediately (async), no done; after release in_ready=1 and row_count=0.
- Single row: 1 row (7,8,9,10).
  - Required: a1=7 at t+1, a2=8 at t+2, a3=9 at t+3, a4=10 at t+4 with done=1; en_out high only at t+1.

Source files
------------

// File: rtl/array_pkg.sv
// array_pkg
// Shared definitions for the systolic-array input feeder and its consumers.
//   DATA_W   width of one activation value
//   LANES    number of array rows / feeder lanes (lane k skewed by k cycles)
//   DEPTH    rows buffered per batch (power of 2)
//   state_e  feeder control states
//   lane_slice() extracts lane k from a packed row
package array_pkg;

    localparam int DATA_W       = 8;
    localparam int LANES        = 4;
    localparam int DEPTH        = 4;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    // Zero-padding cycles needed to flush the deepest skew chain.
    localparam int DRAIN_CYCLES = LANES - 1;
    localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] lane_slice(
        input logic [LANES*DATA_W-1:0] row,
        input int                      k
    );
        return row[k*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/skew_delay.sv
// skew_delay
// DELAY+1 register stages in series, all cleared by reset. DELAY=0 is a single
// register, which keeps every lane's output registered and aligned with lane 0.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   d_i   input value
//   q_o   value delayed by DELAY+1 clock edges
module skew_delay #(
    parameter int DELAY  = 0,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] stage_q [DELAY+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i <= DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DELAY];

endmodule

// File: rtl/array_feeder.sv
// array_feeder
// Buffers up to DEPTH activation rows, then on a start pulse streams them into
// the 4x4 systolic array with lane k delayed k cycles and zero padding.
// Ports:
//   clk, rst_b            clock; asynchronous active-high reset
//   in_valid/in_ready     row write handshake (in_ready is combinational on start)
//   in_data               packed row, lane k = in_data[k*DATA_W +: DATA_W]
//   start                 begin streaming the buffered batch
//   busy, done            batch in progress; one-cycle pulse with last output
//   row_count             rows currently buffered
//   en_out                array enable, high while lane 0 carries data
//   a1_out..a4_out        lane 0..3 activations
module array_feeder
    import array_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        row_count,
    output logic                    en_out,
    output logic [DATA_W-1:0]       a1_out,
    output logic [DATA_W-1:0]       a2_out,
    output logic [DATA_W-1:0]       a3_out,
    output logic [DATA_W-1:0]       a4_out
);

    state_e              state_q,  state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [DRAIN_W-1:0]  drain_q,  drain_d;
    logic                en_q,     en_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic                wr_en;
    logic                rd_fire;
    logic                last_read;

    logic [LANES*DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0]       lane_in  [LANES];
    logic [DATA_W-1:0]       lane_out [LANES];

    assign last_read = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

    // The read of row 0 happens on the same edge that samples start, so the
    // first row reaches the array one cycle after start.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drain_d  = drain_q;
        done_d   = 1'b0;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        rd_fire  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = (count_q < CNT_W'(DEPTH)) && !start;
                wr_en    = in_valid && in_ready;
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                if (start && (count_q != '0)) begin
                    rd_fire = 1'b1;
                end
            end
            ST_STREAM: begin
                rd_fire = 1'b1;
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    drain_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            drain_d  = '0;
            state_d  = last_read ? ST_DRAIN : ST_STREAM;
        end
    end

    assign en_d   = rd_fire;
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drain_q  <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drain_q  <= drain_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Row storage has no reset: row_count gates every read, so stale contents
    // are never observable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Lanes are fed zeros whenever no row is being read, which both pads the
    // skew and flushes stale data out of the chains.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_in[gi] = rd_fire ? lane_slice(mem_q[rd_ptr_q], gi) : '0;

            skew_delay #(
                .DELAY  (gi),
                .DATA_W (DATA_W)
            ) u_skew (
                .clk (clk),
                .rst (rst_b),
                .d_i (lane_in[gi]),
                .q_o (lane_out[gi])
            );
        end
    endgenerate

    assign a1_out    = lane_out[0];
    assign a2_out    = lane_out[1];
    assign a3_out    = lane_out[2];
    assign a4_out    = lane_out[3];
    assign en_out    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign row_count = count_q;

endmodule
